// File: rtl/cavlc_pkg.sv
// Shared types and constants for the CAVLC level decoder.
package cavlc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TONES,
        ST_LEVELS,
        ST_FLUSH
    } cavlcState_t;

    localparam int MAX_PREFIX     = 15;
    localparam int ESC14_SUFFIX   = 4;
    localparam int ESC15_SUFFIX   = 12;
    localparam int MAX_SUFFIX_LEN = 6;

    // Decoded level plus the suffixLength to use for the next symbol.
    typedef struct packed {
        logic signed [13:0] level;
        logic [2:0]         nextSuffixLen;
    } levelResult_t;

endpackage

// File: rtl/cavlc_lzc16.sv
// Combinational 16-bit leading-zero counter; Count=16 when no bit is set.
module cavlc_lzc16 (
    input  logic [15:0] Din,
    output logic [4:0]  Count
);

    // Scanning upward lets the highest set bit win.
    always_comb begin
        Count = 5'd16;
        for (int i = 0; i < 16; i++) begin
            if (Din[i]) Count = 5'(15 - i);
        end
    end

endmodule

// File: rtl/cavlc_level_decoder.sv
// CAVLC level decoder: trailing-one signs, then level_prefix/suffix decode
// with suffixLength adaptation, one level per cycle behind a ready/valid output.
module cavlc_level_decoder
    import cavlc_pkg::*;
#(
    parameter int LEVEL_W   = 16,
    parameter int WIN_W     = 32,
    parameter int MAX_COEFF = 16
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      Start,
    input  logic [4:0]                TotalCoeff,
    input  logic [1:0]                TrailingOnes,
    input  logic [WIN_W-1:0]          Bitstream,
    input  logic                      BitsValid,
    output logic [4:0]                NumShift,
    output logic                      ShiftEn,
    output logic signed [LEVEL_W-1:0] LevelOut,
    output logic [3:0]                LevelIdx,
    output logic                      LevelValid,
    input  logic                      OutReady,
    output logic                      LevelLast,
    output logic                      Done,
    output logic                      Busy,
    output logic                      Error
);

    cavlcState_t state;
    logic [4:0]  tcReg;
    logic [1:0]  t1Reg;
    logic [4:0]  idx;
    logic [2:0]  suffixLen;
    logic        firstLevel;

    logic [4:0]                prefix;
    logic [3:0]                suffixSize;
    logic [WIN_W-1:0]          afterPrefix;
    logic [11:0]               suffixWin;
    logic [11:0]               suffix;
    levelResult_t              levelRes;
    logic                      roomOk;
    logic                      symbolReady;
    logic                      noOne;
    logic                      consume;
    logic                      prefixErr;
    logic                      lastSym;
    logic signed [LEVEL_W-1:0] nextLevel;

    function automatic levelResult_t decodeLevel(
        input logic [4:0]  pfx,
        input logic [11:0] sfx,
        input logic [2:0]  sl,
        input logic        addTwo
    );
        logic [13:0]  levelCode;
        logic [13:0]  mag;
        logic [2:0]   sl1;
        levelResult_t r;
        levelCode = (14'(pfx) << sl) + 14'(sfx);
        if (pfx == 5'(MAX_PREFIX) && sl == 3'd0) levelCode = levelCode + 14'd15;
        if (addTwo) levelCode = levelCode + 14'd2;
        if (levelCode[0]) begin
            mag     = (levelCode + 14'd1) >> 1;
            r.level = -$signed(mag);
        end else begin
            mag     = (levelCode + 14'd2) >> 1;
            r.level = $signed(mag);
        end
        // The zero-to-one bump happens before the magnitude threshold test.
        sl1 = (sl == 3'd0) ? 3'd1 : sl;
        if (mag > (14'd3 << (sl1 - 3'd1)) && sl1 < 3'(MAX_SUFFIX_LEN)) sl1 = sl1 + 3'd1;
        r.nextSuffixLen = sl1;
        return r;
    endfunction

    cavlc_lzc16 uLzc (
        .Din   (Bitstream[WIN_W-1 -: 16]),
        .Count (prefix)
    );

    always_comb begin
        if (prefix == 5'(MAX_PREFIX))
            suffixSize = 4'(ESC15_SUFFIX);
        else if (prefix == 5'd14 && suffixLen == 3'd0)
            suffixSize = 4'(ESC14_SUFFIX);
        else
            suffixSize = {1'b0, suffixLen};
    end

    assign afterPrefix = Bitstream << (prefix + 5'd1);
    assign suffixWin   = afterPrefix[WIN_W-1 -: 12];
    assign suffix      = suffixWin >> (4'd12 - suffixSize);
    assign levelRes    = decodeLevel(prefix, suffix, suffixLen, firstLevel && (t1Reg != 2'd3));

    assign roomOk      = !LevelValid || OutReady;
    assign symbolReady = (state == ST_TONES || state == ST_LEVELS) && BitsValid && roomOk;
    assign noOne       = (state == ST_LEVELS) && (prefix > 5'(MAX_PREFIX));
    assign consume     = symbolReady && !noOne;
    assign prefixErr   = symbolReady && noOne;
    assign lastSym     = (idx + 5'd1) == tcReg;

    assign ShiftEn  = consume;
    assign NumShift = !consume ? 5'd0 :
                      (state == ST_TONES) ? 5'd1 :
                      prefix + 5'd1 + {1'b0, suffixSize};

    always_comb begin
        if (state == ST_TONES)
            nextLevel = Bitstream[WIN_W-1] ? {LEVEL_W{1'b1}} : LEVEL_W'(1);
        else
            nextLevel = LEVEL_W'($signed(levelRes.level));
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state      <= ST_IDLE;
            tcReg      <= '0;
            t1Reg      <= '0;
            idx        <= '0;
            suffixLen  <= '0;
            firstLevel <= 1'b0;
            LevelOut   <= '0;
            LevelIdx   <= '0;
            LevelValid <= 1'b0;
            LevelLast  <= 1'b0;
            Done       <= 1'b0;
            Busy       <= 1'b0;
            Error      <= 1'b0;
        end else begin
            Done  <= 1'b0;
            Error <= 1'b0;

            if (consume) begin
                LevelValid <= 1'b1;
                LevelOut   <= nextLevel;
                LevelIdx   <= idx[3:0];
                LevelLast  <= lastSym;
            end else if (OutReady) begin
                LevelValid <= 1'b0;
                LevelLast  <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (Start) begin
                        if (int'(TotalCoeff) > MAX_COEFF) begin
                            Error <= 1'b1;
                        end else begin
                            Busy       <= 1'b1;
                            tcReg      <= TotalCoeff;
                            t1Reg      <= TrailingOnes;
                            idx        <= '0;
                            firstLevel <= 1'b1;
                            suffixLen  <= (TotalCoeff > 5'd10 && TrailingOnes != 2'd3) ? 3'd1 : 3'd0;
                            if (TotalCoeff == 5'd0)
                                state <= ST_FLUSH;
                            else if (TrailingOnes != 2'd0)
                                state <= ST_TONES;
                            else
                                state <= ST_LEVELS;
                        end
                    end
                end
                ST_TONES: begin
                    if (consume) begin
                        idx <= idx + 5'd1;
                        if (lastSym)
                            state <= ST_FLUSH;
                        else if ((idx + 5'd1) == {3'b0, t1Reg})
                            state <= ST_LEVELS;
                    end
                end
                ST_LEVELS: begin
                    if (prefixErr) begin
                        Error <= 1'b1;
                        Busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else if (consume) begin
                        idx        <= idx + 5'd1;
                        suffixLen  <= levelRes.nextSuffixLen;
                        firstLevel <= 1'b0;
                        if (lastSym) state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (roomOk) begin
                        Done  <= 1'b1;
                        Busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cavlc_level_decoder.sv
// Scoreboard bench: chosen levels are CAVLC-encoded into a bit queue and must come back out.
module tb_cavlc_level_decoder;

    localparam int LEVEL_W   = 16;
    localparam int WIN_W     = 32;
    localparam int MAX_COEFF = 16;

    logic                      Clk = 1'b0;
    logic                      Reset;
    logic                      Start;
    logic [4:0]                TotalCoeff;
    logic [1:0]                TrailingOnes;
    logic [WIN_W-1:0]          Bitstream;
    logic                      BitsValid;
    logic [4:0]                NumShift;
    logic                      ShiftEn;
    logic signed [LEVEL_W-1:0] LevelOut;
    logic [3:0]                LevelIdx;
    logic                      LevelValid;
    logic                      OutReady;
    logic                      LevelLast;
    logic                      Done;
    logic                      Busy;
    logic                      Error;

    typedef struct {
        int level;
        int idx;
        bit last;
    } expLevel_t;

    bit        bitQ[$];
    expLevel_t expQ[$];
    int        lenQ[$];

    int nCompared   = 0;
    int nMismatch   = 0;
    int doneCount   = 0;
    int errCount    = 0;
    int validPct    = 100;
    int readyPct    = 100;
    int stallDelay  = 0;
    int stallCycles = 0;
    int blkLevels[16];
    bit t1Bits[3];

    cavlc_level_decoder #(
        .LEVEL_W   (LEVEL_W),
        .WIN_W     (WIN_W),
        .MAX_COEFF (MAX_COEFF)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Start        (Start),
        .TotalCoeff   (TotalCoeff),
        .TrailingOnes (TrailingOnes),
        .Bitstream    (Bitstream),
        .BitsValid    (BitsValid),
        .NumShift     (NumShift),
        .ShiftEn      (ShiftEn),
        .LevelOut     (LevelOut),
        .LevelIdx     (LevelIdx),
        .LevelValid   (LevelValid),
        .OutReady     (OutReady),
        .LevelLast    (LevelLast),
        .Done         (Done),
        .Busy         (Busy),
        .Error        (Error)
    );

    initial forever #5 Clk = ~Clk;

    function automatic void check(input string name, input longint act, input longint req);
        nCompared++;
        if (act != req) begin
            nMismatch++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endfunction

    task automatic pushBits(input int val, input int n);
        for (int b = n - 1; b >= 0; b--) bitQ.push_back(bit'((val >> b) & 1));
    endtask

    function automatic int randLevel(input bit needBig);
        int m;
        case ($urandom_range(2))
            0:       m = int'($urandom_range(3, 1));
            1:       m = int'($urandom_range(20, 1));
            default: m = int'($urandom_range(2000, 1));
        endcase
        if (needBig && m < 2) m = 2;
        return ($urandom_range(1) == 1) ? m : -m;
    endfunction

    // Encoder from the H.264 level rules; the decoder must invert it.
    task automatic encodeBlock(input int tc, input int t1);
        int sl, lc, pfx, ss, sfx, mag, lvl, idx;
        expLevel_t e;
        bitQ.delete();
        sl  = (tc > 10 && t1 < 3) ? 1 : 0;
        idx = 0;
        for (int i = 0; i < t1; i++) begin
            bitQ.push_back(t1Bits[i]);
            lenQ.push_back(1);
            e.level = t1Bits[i] ? -1 : 1;
            e.idx   = idx;
            e.last  = (idx == tc - 1);
            expQ.push_back(e);
            idx++;
        end
        for (int k = 0; k < tc - t1; k++) begin
            lvl = blkLevels[k];
            mag = (lvl < 0) ? -lvl : lvl;
            lc  = (lvl > 0) ? 2 * lvl - 2 : 2 * mag - 1;
            if (k == 0 && t1 < 3) lc -= 2;
            if (sl == 0) begin
                if (lc < 14)      begin pfx = lc; ss = 0;  sfx = 0;       end
                else if (lc < 30) begin pfx = 14; ss = 4;  sfx = lc - 14; end
                else              begin pfx = 15; ss = 12; sfx = lc - 30; end
            end else begin
                if (lc < (15 << sl)) begin pfx = lc >> sl; ss = sl; sfx = lc % (1 << sl); end
                else                 begin pfx = 15; ss = 12; sfx = lc - (15 << sl); end
            end
            pushBits(0, pfx);
            pushBits(1, 1);
            pushBits(sfx, ss);
            lenQ.push_back(pfx + 1 + ss);
            e.level = lvl;
            e.idx   = idx;
            e.last  = (idx == tc - 1);
            expQ.push_back(e);
            idx++;
            if (sl == 0) sl = 1;
            if (mag > (3 << (sl - 1)) && sl < 6) sl++;
        end
        for (int i = 0; i < 32; i++) bitQ.push_back(bit'($urandom_range(1)));
    endtask

    // Driver: window, BitsValid and OutReady change just after each rising edge.
    initial begin : driver
        logic [WIN_W-1:0] win;
        forever begin
            @(posedge Clk);
            #1;
            for (int b = 0; b < WIN_W; b++) win[WIN_W-1-b] = (b < bitQ.size()) ? bitQ[b] : 1'b0;
            Bitstream = win;
            BitsValid = (bitQ.size() >= 28) && (int'($urandom_range(99)) < validPct);
            if (stallDelay > 0) begin
                stallDelay--;
                if (stallDelay == 0) stallCycles = 3;
            end
            if (stallCycles > 0) begin
                OutReady = 1'b0;
                stallCycles--;
            end else begin
                OutReady = int'($urandom_range(99)) < readyPct;
            end
        end
    end

    // Monitor: consumes lengths and levels from the scoreboard queues.
    initial begin : monitor
        expLevel_t e;
        int n;
        forever begin
            @(negedge Clk);
            if (!Reset) begin
                if (ShiftEn) begin
                    check("consume expected", longint'(lenQ.size() > 0), 1);
                    if (lenQ.size() > 0) begin
                        n = lenQ.pop_front();
                        check("NumShift", NumShift, n);
                        repeat (n) if (bitQ.size() > 0) void'(bitQ.pop_front());
                    end
                end else begin
                    check("NumShift idle", NumShift, 0);
                end
                if (!BitsValid) check("ShiftEn without bits", ShiftEn, 0);
                if (LevelValid && !OutReady) check("ShiftEn while full", ShiftEn, 0);
                if (LevelValid && OutReady) begin
                    check("level expected", longint'(expQ.size() > 0), 1);
                    if (expQ.size() > 0) begin
                        e = expQ.pop_front();
                        check("LevelOut", longint'(LevelOut), e.level);
                        check("LevelIdx", LevelIdx, e.idx);
                        check("LevelLast", LevelLast, e.last);
                    end
                end
                if (Done)  doneCount++;
                if (Error) errCount++;
            end
        end
    end

    task automatic runBlock(input int tc, input int t1, input string nm);
        int d0, e0, t;
        @(negedge Clk);
        #1;
        encodeBlock(tc, t1);
        d0 = doneCount;
        e0 = errCount;
        @(posedge Clk);
        #1;
        Start        = 1'b1;
        TotalCoeff   = 5'(tc);
        TrailingOnes = 2'(t1);
        @(posedge Clk);
        #1;
        Start = 1'b0;
        check({nm, " Busy after Start"}, Busy, 1);
        @(posedge Clk);
        #1;
        if (tc == 0) check({nm, " Done at T+2"}, Done, 1);
        t = 0;
        while (doneCount == d0 && errCount == e0 && t < 500) begin
            @(negedge Clk);
            t++;
        end
        check({nm, " Done count"}, doneCount - d0, 1);
        check({nm, " Error count"}, errCount - e0, 0);
        check({nm, " levels outstanding"}, expQ.size(), 0);
        check({nm, " symbols outstanding"}, lenQ.size(), 0);
        expQ.delete();
        lenQ.delete();
        @(posedge Clk);
        #1;
        check({nm, " Busy after Done"}, Busy, 0);
    endtask

    task automatic runError(input int tc, input string nm);
        int d0, e0, t;
        @(negedge Clk);
        #1;
        bitQ.delete();
        repeat (40) bitQ.push_back(1'b0);
        d0 = doneCount;
        e0 = errCount;
        @(posedge Clk);
        #1;
        Start        = 1'b1;
        TotalCoeff   = 5'(tc);
        TrailingOnes = 2'd0;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        t = 0;
        while (errCount == e0 && t < 50) begin
            @(negedge Clk);
            t++;
        end
        check({nm, " Error count"}, errCount - e0, 1);
        check({nm, " Done count"}, doneCount - d0, 0);
        @(posedge Clk);
        #1;
        check({nm, " Busy after Error"}, Busy, 0);
    endtask

    initial begin : main
        int tc, t1;
        Reset        = 1'b1;
        Start        = 1'b0;
        TotalCoeff   = '0;
        TrailingOnes = '0;
        Bitstream    = '0;
        BitsValid    = 1'b0;
        OutReady     = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        check("reset LevelOut", longint'(LevelOut), 0);
        check("reset LevelIdx", LevelIdx, 0);
        check("reset LevelValid", LevelValid, 0);
        check("reset LevelLast", LevelLast, 0);
        check("reset Done", Done, 0);
        check("reset Busy", Busy, 0);
        check("reset Error", Error, 0);
        check("reset ShiftEn", ShiftEn, 0);
        check("reset NumShift", NumShift, 0);
        Reset = 1'b0;

        t1Bits = '{1'b1, 1'b0, 1'b1};
        runBlock(3, 3, "three trailing ones");
        blkLevels[0] = 2;
        runBlock(1, 0, "level +2");
        blkLevels[0] = -11;
        runBlock(1, 0, "escape 14");
        blkLevels[0] = 17;
        runBlock(1, 0, "escape 15");
        blkLevels[0] = 5;
        for (int k = 1; k < 11; k++) blkLevels[k] = randLevel(1'b0);
        runBlock(11, 0, "suffixLength start 1");
        runBlock(0, 0, "empty block");

        for (int k = 0; k < 8; k++) blkLevels[k] = randLevel(k == 0);
        stallDelay = 3;
        runBlock(8, 0, "stall");

        runError(1, "no leading one");
        runError(MAX_COEFF + 1, "TotalCoeff too large");

        // Reset mid-block, then a clean block afterwards.
        @(negedge Clk);
        #1;
        for (int k = 0; k < 16; k++) blkLevels[k] = randLevel(1'b0);
        t1Bits = '{1'b0, 1'b0, 1'b0};
        encodeBlock(12, 1);
        @(posedge Clk);
        #1;
        Start        = 1'b1;
        TotalCoeff   = 5'd12;
        TrailingOnes = 2'd1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        Reset = 1'b1;
        #1;
        check("midreset LevelOut", longint'(LevelOut), 0);
        check("midreset LevelIdx", LevelIdx, 0);
        check("midreset LevelValid", LevelValid, 0);
        check("midreset LevelLast", LevelLast, 0);
        check("midreset Done", Done, 0);
        check("midreset Busy", Busy, 0);
        check("midreset Error", Error, 0);
        check("midreset ShiftEn", ShiftEn, 0);
        check("midreset NumShift", NumShift, 0);
        bitQ.delete();
        expQ.delete();
        lenQ.delete();
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        for (int k = 0; k < 16; k++) blkLevels[k] = randLevel(k == 0);
        runBlock(6, 0, "after reset");

        validPct = 80;
        readyPct = 70;
        for (int n = 0; n < 40; n++) begin
            tc = int'($urandom_range(MAX_COEFF));
            t1 = int'($urandom_range((tc < 3) ? tc : 3));
            for (int i = 0; i < 3; i++) t1Bits[i] = bit'($urandom_range(1));
            for (int k = 0; k < 16; k++) blkLevels[k] = randLevel(k == 0 && t1 < 3);
            runBlock(tc, t1, "random block");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
        $fatal(1);
    end

endmodule
